gene_sweep_driver: RTL and testbench
====================================

Name: gene_sweep_driver

Overview:
- Upstream stage of the cycle detector in the gene-network datapath.
- Sweeps every 8-bit initial gene state and iterates a threshold Boolean network update rule from each one.
- Drives the state trajectory and current initial value to the detector, and consumes its cycle flag.
- Classifies each trajectory as fixed point, cycle or timeout, and emits one result record per initial state.

Parameters:
- N_GENES, 8, gene count; state width. Masks are N_GENES*N_GENES bits.
- MAX_STEPS, 64, step budget per trajectory before timeout (1..255).

Ports:
- clk  in  1  clock; all flops rise-edge.
- rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle pulse; begins a sweep when idle.
- act_mask  in  64  activator rows; bits [8i+7:8i] = genes activating gene i.
- inh_mask  in  64  inhibitor rows; same layout.
- cycle_in  in  1  cycle flag returned by the downstream detector.
- init_out  out  8  current initial state; the detector's init-change input.
- x  out  8  current gene state x[t]; feeds the detector.
- x_valid  out  1  high on cycles where x advanced this step.
- busy  out  1  sweep in progress.
- done  out  1  sweep complete; held until next accepted start.
- res_valid  out  1  one-cycle result strobe.
- res_init  out  8  initial state of the finished trajectory.
- res_kind  out  2  01 fixed point, 10 cycle, 11 timeout.
- res_state  out  8  final state: fixed point value, cycle point, or state at timeout.
- res_steps  out  8  step_cnt at termination.

Behaviour:
- Update rule, per gene i:
  - a = popcount(x & act_row_i), h = popcount(x & inh_row_i); each is 4-bit, no overflow.
  - nx[i] = 1 if a>h; 0 if a<h; x[i] if a==h.
  - nx is combinational from x.
- Reset: all outputs and registers 0; FSM goes to IDLE. Reset mid-sweep aborts immediately; no partial result is emitted.
- FSM states: IDLE, LOAD, RUN, NEXT, DONE.
- IDLE:
  - start=1 -> LOAD with init_out<=0.
  - busy=0.
  - start while busy is ignored.
- LOAD (1 cycle):
  - x<=init_out, step_cnt<=0, x_valid=0.
  - Always goes to RUN. The one-cycle hold lets the detector clear on the init change.
- RUN: each cycle evaluates the following in priority order:
  1. nx==x: res_kind=01, res_state=x -> NEXT.
  2. cycle_in=1: res_kind=10, res_state=x -> NEXT.
  3. step_cnt==MAX_STEPS: res_kind=11, res_state=x -> NEXT.
  4. Otherwise: x<=nx, step_cnt<=step_cnt+1, x_valid<=1.
  - On any termination: res_valid=1 for exactly that cycle; res_init=init_out; res_steps=step_cnt. Result registers hold until the next strobe.
- NEXT (1 cycle):
  - init_out==8'hFF -> DONE.
  - Otherwise init_out<=init_out+1 -> LOAD.
  - No wrap to 0 within a sweep.
- DONE: done=1, busy=0. start -> clear done, init_out<=0 -> LOAD.
- busy=1 in LOAD, RUN, NEXT.
- Simultaneous events: fixed point with cycle_in=1 reports fixed; cycle_in=1 on the budget step reports cycle.
- cycle_in is ignored outside RUN.
- Latency: a trajectory ending at step k costs k+3 cycles (LOAD, k+1 RUN, NEXT).

Test Plan:
- All masks 0, start: every state is a fixed point -> 256 res_valid strobes with res_kind=01, res_steps=0, res_init 0..255 in order; done rises 768 cycles after start; busy falls with it.
- Self-inhibition (inh row i = 1<<i, act=0), init 0xFF: x 0xFF->0x00 -> res_state=0x00, res_kind=01, res_steps=1.
- Rotate network (act row i = 1<<((i+7)%8), inh row i = 1<<i), cycle_in=0, MAX_STEPS=16:
  - init 0x01 -> x walks 0x01,0x02,0x04,... -> res_kind=11, res_steps=16, res_state=0x01.
  - inits 0x00 and 0xFF -> res_kind=01.
- Rotate network, bench asserts cycle_in when step_cnt==3 for init 0x01 -> res_kind=10, res_state=0x08, res_steps=3. Same cycle with a fixed point present -> res_kind=01.
- Assert rst during RUN at init 0x05 -> all outputs 0 asynchronously, FSM in IDLE, no res_valid. A new start resumes from init 0x00.
- start pulsed during RUN -> ignored; sweep continues. start in DONE -> done clears next cycle and a new sweep begins.

Source files
------------

// File: rtl/gene_sweep_driver.sv
// Sweeps every initial gene state, iterates the threshold Boolean network from each one,
// and emits one classified result (fixed point / cycle / timeout) per trajectory.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | waiting for start; outputs quiet
//   LOAD   | x <= init_out, step count cleared; detector sees init change
//   RUN    | one network update per cycle until fixed / cycle / budget
//   NEXT   | advance init_out, or finish after the all-ones state
//   DONE   | sweep complete; done held until the next start
module gene_sweep_driver #(
    parameter int N_GENES   = 8,
    parameter int MAX_STEPS = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [N_GENES*N_GENES-1:0]   act_mask,
    input  logic [N_GENES*N_GENES-1:0]   inh_mask,
    input  logic                         cycle_in,
    output logic [N_GENES-1:0]           init_out,
    output logic [N_GENES-1:0]           x,
    output logic                         x_valid,
    output logic                         busy,
    output logic                         done,
    output logic                         res_valid,
    output logic [N_GENES-1:0]           res_init,
    output logic [1:0]                   res_kind,
    output logic [N_GENES-1:0]           res_state,
    output logic [7:0]                   res_steps
);

    localparam int CW = $clog2(N_GENES + 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_NEXT = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [1:0] KIND_FIXED   = 2'b01;
    localparam logic [1:0] KIND_CYCLE   = 2'b10;
    localparam logic [1:0] KIND_TIMEOUT = 2'b11;

    localparam logic [7:0]         STEP_LIMIT = 8'(MAX_STEPS);
    localparam logic [N_GENES-1:0] LAST_INIT  = '1;

    logic [2:0]         state_q, state_d;
    logic [N_GENES-1:0] init_q, init_d;
    logic [N_GENES-1:0] x_q, x_d;
    logic [7:0]         step_q, step_d;
    logic               x_valid_q, x_valid_d;
    logic               res_valid_q, res_valid_d;
    logic [N_GENES-1:0] res_init_q, res_init_d;
    logic [1:0]         res_kind_q, res_kind_d;
    logic [N_GENES-1:0] res_state_q, res_state_d;
    logic [7:0]         res_steps_q, res_steps_d;

    logic [N_GENES-1:0] nx;
    logic               term;
    logic [1:0]         term_kind;

    function automatic logic [CW-1:0] popcnt(input logic [N_GENES-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < N_GENES; i++) begin
            c = c + CW'(v[i]);
        end
        return c;
    endfunction

    // Majority of active activators vs inhibitors; a tie keeps the gene's own value.
    for (genvar g = 0; g < N_GENES; g++) begin : g_gene
        logic [CW-1:0] a_cnt;
        logic [CW-1:0] h_cnt;
        assign a_cnt = popcnt(x_q & act_mask[g*N_GENES +: N_GENES]);
        assign h_cnt = popcnt(x_q & inh_mask[g*N_GENES +: N_GENES]);
        assign nx[g] = (a_cnt > h_cnt) ? 1'b1 :
                       (a_cnt < h_cnt) ? 1'b0 : x_q[g];
    end

    // Termination priority: fixed point beats cycle flag, cycle flag beats the budget.
    always_comb begin
        term      = 1'b0;
        term_kind = 2'b00;
        if (nx == x_q) begin
            term      = 1'b1;
            term_kind = KIND_FIXED;
        end else if (cycle_in) begin
            term      = 1'b1;
            term_kind = KIND_CYCLE;
        end else if (step_q == STEP_LIMIT) begin
            term      = 1'b1;
            term_kind = KIND_TIMEOUT;
        end
    end

    always_comb begin
        state_d     = state_q;
        init_d      = init_q;
        x_d         = x_q;
        step_d      = step_q;
        x_valid_d   = 1'b0;
        res_valid_d = 1'b0;
        res_init_d  = res_init_q;
        res_kind_d  = res_kind_q;
        res_state_d = res_state_q;
        res_steps_d = res_steps_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    init_d  = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                x_d     = init_q;
                step_d  = 8'd0;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (term) begin
                    res_valid_d = 1'b1;
                    res_init_d  = init_q;
                    res_kind_d  = term_kind;
                    res_state_d = x_q;
                    res_steps_d = step_q;
                    state_d     = S_NEXT;
                end else begin
                    x_d       = nx;
                    step_d    = step_q + 8'd1;
                    x_valid_d = 1'b1;
                end
            end
            S_NEXT: begin
                if (init_q == LAST_INIT) begin
                    state_d = S_DONE;
                end else begin
                    init_d  = init_q + N_GENES'(1);
                    state_d = S_LOAD;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            init_q      <= '0;
            x_q         <= '0;
            step_q      <= 8'd0;
            x_valid_q   <= 1'b0;
            res_valid_q <= 1'b0;
            res_init_q  <= '0;
            res_kind_q  <= 2'b00;
            res_state_q <= '0;
            res_steps_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            init_q      <= init_d;
            x_q         <= x_d;
            step_q      <= step_d;
            x_valid_q   <= x_valid_d;
            res_valid_q <= res_valid_d;
            res_init_q  <= res_init_d;
            res_kind_q  <= res_kind_d;
            res_state_q <= res_state_d;
            res_steps_q <= res_steps_d;
        end
    end

    assign init_out  = init_q;
    assign x         = x_q;
    assign x_valid   = x_valid_q;
    assign busy      = (state_q == S_LOAD) || (state_q == S_RUN) || (state_q == S_NEXT);
    assign done      = (state_q == S_DONE);
    assign res_valid = res_valid_q;
    assign res_init  = res_init_q;
    assign res_kind  = res_kind_q;
    assign res_state = res_state_q;
    assign res_steps = res_steps_q;

endmodule

// File: tb/tb_gene_sweep_driver.sv
// Bench for gene_sweep_driver: whole sweeps compared against a trajectory-level reference
// model, with cycle_in driven from a precomputed per-cycle schedule.
module tb_gene_sweep_driver;

    localparam int MS = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [63:0] act_m = '0;
    logic [63:0] inh_m = '0;
    logic        cycle_in = 1'b0;
    logic [7:0]  init_out, x, res_init, res_state, res_steps;
    logic [1:0]  res_kind;
    logic        x_valid, busy, done, res_valid;

    gene_sweep_driver #(.N_GENES(8), .MAX_STEPS(MS)) dut (
        .clk(clk), .rst(rst), .start(start),
        .act_mask(act_m), .inh_mask(inh_m), .cycle_in(cycle_in),
        .init_out(init_out), .x(x), .x_valid(x_valid), .busy(busy), .done(done),
        .res_valid(res_valid), .res_init(res_init), .res_kind(res_kind),
        .res_state(res_state), .res_steps(res_steps)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    int cyc_at [256];
    int exp_kind [256], exp_state [256], exp_steps [256], exp_cyc [256], exp_off [256];
    int exp_done_cyc, exp_xv;
    bit cin_sched [8192];
    bit noise_en;

    int got_kind [256], got_state [256], got_steps [256], got_cyc [256];
    int got_n, order_err, got_done_cyc, got_xv;
    logic got_busy0, got_done0, got_busy_done;
    logic [7:0] got_init0;

    // Spec update rule, evaluated gene by gene.
    function automatic logic [7:0] ref_next(input logic [7:0] s);
        logic [7:0] r;
        int a, h;
        for (int i = 0; i < 8; i++) begin
            a = $countones(s & act_m[8*i +: 8]);
            h = $countones(s & inh_m[8*i +: 8]);
            if (a > h)      r[i] = 1'b1;
            else if (a < h) r[i] = 1'b0;
            else            r[i] = s[i];
        end
        return r;
    endfunction

    // Whole-sweep expectation: per-init outcome plus the cycle timeline (k+3 cycles each).
    function automatic void model_sweep();
        int off, st, kind;
        logic [7:0] s, n;
        for (int e = 0; e < 8192; e++) cin_sched[e] = 1'b0;
        off = 0;
        exp_xv = 0;
        for (int v = 0; v < 256; v++) begin
            s = 8'(v);
            st = 0;
            kind = 0;
            while (kind == 0) begin
                n = ref_next(s);
                if (n == s)               kind = 1;
                else if (cyc_at[v] == st) kind = 2;
                else if (st == MS)        kind = 3;
                else begin
                    s = n;
                    st++;
                end
            end
            exp_off[v]   = off;
            exp_kind[v]  = kind;
            exp_state[v] = int'(s);
            exp_steps[v] = st;
            exp_cyc[v]   = off + 2 + st;
            if (cyc_at[v] >= 0 && cyc_at[v] <= st) cin_sched[off + 1 + cyc_at[v]] = 1'b1;
            if (noise_en) begin
                cin_sched[off]          = 1'($urandom_range(0, 1));
                cin_sched[off + 2 + st] = 1'($urandom_range(0, 1));
            end
            exp_xv += st;
            off += st + 3;
        end
        exp_done_cyc = off;
    endfunction

    // Pulse start, then record DUT activity each cycle (e = edges since the start edge).
    task automatic run_sweep(input int stop_at, input int start_at);
        int e;
        got_n = 0; order_err = 0; got_done_cyc = -1; got_xv = 0;
        for (int v = 0; v < 256; v++) begin
            got_kind[v] = -1; got_state[v] = -1; got_steps[v] = -1; got_cyc[v] = -1;
        end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        e = 0;
        got_busy0 = busy; got_done0 = done; got_init0 = init_out;
        while (e < exp_done_cyc + 20) begin
            cycle_in = (e < 8192) ? cin_sched[e] : 1'b0;
            start    = (e == start_at);
            if (res_valid) begin
                if (int'(res_init) != got_n) order_err++;
                got_kind[res_init]  = int'(res_kind);
                got_state[res_init] = int'(res_state);
                got_steps[res_init] = int'(res_steps);
                got_cyc[res_init]   = e;
                got_n++;
            end
            if (x_valid) got_xv++;
            if (done) begin
                got_done_cyc  = e;
                got_busy_done = busy;
                break;
            end
            if (e == stop_at) break;
            @(posedge clk); #1;
            e++;
        end
        cycle_in = 1'b0;
        start = 1'b0;
        if (stop_at < 0 && got_done_cyc < 0) begin
            n_vec++; n_err++;
            $display("FAIL sweep_timeout: done not seen within %0d cycles, expected at %0d", e, exp_done_cyc);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if ({init_out, x, x_valid, busy, done, res_valid, res_init, res_kind, res_state, res_steps} !== 46'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got init=%h x=%h busy=%b done=%b rv=%b kind=%b, expected all zero",
                     init_out, x, busy, done, res_valid, res_kind);
        end
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_all_zero();
        act_m = '0; inh_m = '0; noise_en = 1'b0;
        for (int v = 0; v < 256; v++) cyc_at[v] = -1;
        model_sweep();
        run_sweep(-1, -1);
        n_vec++;
        if (got_busy0 !== 1'b1) begin n_err++; $display("FAIL zero_busy_load: got %b expected 1", got_busy0); end
        n_vec++;
        if (got_n !== 256 || order_err !== 0) begin
            n_err++; $display("FAIL zero_strobes: got %0d strobes (%0d out of order) expected 256", got_n, order_err);
        end
        for (int v = 0; v < 256; v++) begin
            n_vec++;
            if (got_kind[v] !== 1 || got_steps[v] !== 0 || got_state[v] !== v || got_cyc[v] !== 3*v + 2) begin
                n_err++;
                $display("FAIL zero_rec[%0d]: got kind=%0d steps=%0d state=%0d cyc=%0d expected 1/0/%0d/%0d",
                         v, got_kind[v], got_steps[v], got_state[v], got_cyc[v], v, 3*v + 2);
            end
        end
        n_vec++;
        if (got_done_cyc !== 768 || got_busy_done !== 1'b0) begin
            n_err++; $display("FAIL zero_done: got done at %0d busy=%b expected 768 busy=0", got_done_cyc, got_busy_done);
        end
        n_vec++;
        if (got_xv !== 0) begin n_err++; $display("FAIL zero_xvalid: got %0d expected 0", got_xv); end
    endtask

    task automatic test_self_inhibit();
        act_m = '0; noise_en = 1'b0;
        for (int i = 0; i < 8; i++) inh_m[8*i +: 8] = 8'(1 << i);
        for (int v = 0; v < 256; v++) cyc_at[v] = -1;
        model_sweep();
        run_sweep(-1, -1);
        n_vec++;
        if (got_kind[255] !== 1 || got_state[255] !== 0 || got_steps[255] !== 1) begin
            n_err++; $display("FAIL selfinh_ff: got kind=%0d state=%0d steps=%0d expected 1/0/1",
                              got_kind[255], got_state[255], got_steps[255]);
        end
        for (int v = 0; v < 256; v++) begin
            n_vec++;
            if (got_kind[v] !== exp_kind[v] || got_state[v] !== exp_state[v] ||
                got_steps[v] !== exp_steps[v] || got_cyc[v] !== exp_cyc[v]) begin
                n_err++;
                $display("FAIL selfinh_rec[%0d]: got %0d/%0d/%0d@%0d expected %0d/%0d/%0d@%0d", v,
                         got_kind[v], got_state[v], got_steps[v], got_cyc[v],
                         exp_kind[v], exp_state[v], exp_steps[v], exp_cyc[v]);
            end
        end
    endtask

    task automatic set_rotate();
        for (int i = 0; i < 8; i++) begin
            act_m[8*i +: 8] = 8'(1 << ((i + 7) % 8));
            inh_m[8*i +: 8] = 8'(1 << i);
        end
    endtask

    task automatic test_rotate();
        set_rotate();
        noise_en = 1'b0;
        for (int v = 0; v < 256; v++) cyc_at[v] = -1;
        model_sweep();
        run_sweep(-1, -1);
        n_vec++;
        if (got_kind[1] !== 3 || got_steps[1] !== MS || got_state[1] !== 1) begin
            n_err++; $display("FAIL rotate_timeout: got kind=%0d steps=%0d state=%0d expected 3/%0d/1",
                              got_kind[1], got_steps[1], got_state[1], MS);
        end
        n_vec++;
        if (got_kind[0] !== 1 || got_kind[255] !== 1) begin
            n_err++; $display("FAIL rotate_fixed: got kind00=%0d kindFF=%0d expected 1/1", got_kind[0], got_kind[255]);
        end
        n_vec++;
        if (got_done_cyc !== exp_done_cyc || got_xv !== exp_xv) begin
            n_err++; $display("FAIL rotate_timing: got done=%0d xv=%0d expected %0d/%0d",
                              got_done_cyc, got_xv, exp_done_cyc, exp_xv);
        end
    endtask

    task automatic test_cycle_inject();
        set_rotate();
        noise_en = 1'b0;
        for (int v = 0; v < 256; v++) cyc_at[v] = -1;
        cyc_at[1] = 3; cyc_at[0] = 0; cyc_at[255] = 0; cyc_at[2] = MS;
        model_sweep();
        run_sweep(-1, -1);
        n_vec++;
        if (got_kind[1] !== 2 || got_state[1] !== 8 || got_steps[1] !== 3) begin
            n_err++; $display("FAIL cycle_step3: got kind=%0d state=%0d steps=%0d expected 2/8/3",
                              got_kind[1], got_state[1], got_steps[1]);
        end
        n_vec++;
        if (got_kind[0] !== 1 || got_kind[255] !== 1) begin
            n_err++; $display("FAIL cycle_vs_fixed: got kind00=%0d kindFF=%0d expected 1/1", got_kind[0], got_kind[255]);
        end
        n_vec++;
        if (got_kind[2] !== 2 || got_steps[2] !== MS || got_state[2] !== 2) begin
            n_err++; $display("FAIL cycle_on_budget: got kind=%0d steps=%0d state=%0d expected 2/%0d/2",
                              got_kind[2], got_steps[2], got_state[2], MS);
        end
        for (int v = 0; v < 256; v++) begin
            n_vec++;
            if (got_kind[v] !== exp_kind[v] || got_state[v] !== exp_state[v] ||
                got_steps[v] !== exp_steps[v] || got_cyc[v] !== exp_cyc[v]) begin
                n_err++;
                $display("FAIL cycle_rec[%0d]: got %0d/%0d/%0d@%0d expected %0d/%0d/%0d@%0d", v,
                         got_kind[v], got_state[v], got_steps[v], got_cyc[v],
                         exp_kind[v], exp_state[v], exp_steps[v], exp_cyc[v]);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        set_rotate();
        noise_en = 1'b0;
        for (int v = 0; v < 256; v++) cyc_at[v] = -1;
        model_sweep();
        run_sweep(exp_off[5] + 3, -1);
        #3 rst = 1'b1;
        #1;
        n_vec++;
        if ({init_out, x, x_valid, busy, done, res_valid, res_init, res_kind, res_state, res_steps} !== 46'd0) begin
            n_err++;
            $display("FAIL midrun_reset: got init=%h x=%h busy=%b rv=%b kind=%b expected all zero",
                     init_out, x, busy, res_valid, res_kind);
        end
        n_vec++;
        if (got_n !== 5) begin n_err++; $display("FAIL midrun_records: got %0d expected 5", got_n); end
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL midrun_hold: got rv=%b busy=%b expected 0/0", res_valid, busy);
        end
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++; $display("FAIL midrun_idle: got busy=%b done=%b expected 0/0", busy, done);
        end
        run_sweep(-1, -1);
        n_vec++;
        if (got_init0 !== 8'h00 || got_n !== 256) begin
            n_err++; $display("FAIL midrun_restart: got init=%h strobes=%0d expected 00/256", got_init0, got_n);
        end
        for (int v = 0; v < 256; v++) begin
            n_vec++;
            if (got_kind[v] !== exp_kind[v] || got_state[v] !== exp_state[v] || got_steps[v] !== exp_steps[v]) begin
                n_err++;
                $display("FAIL restart_rec[%0d]: got %0d/%0d/%0d expected %0d/%0d/%0d", v,
                         got_kind[v], got_state[v], got_steps[v], exp_kind[v], exp_state[v], exp_steps[v]);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 0) begin
                act_m = {$urandom, $urandom};
                inh_m = {$urandom, $urandom};
                for (int v = 0; v < 256; v++)
                    cyc_at[v] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, MS)) : -1;
            end
            noise_en = 1'b1;
            model_sweep();
            run_sweep(-1, (pass == 0) ? exp_off[10] + 2 : -1);
            if (pass == 1) begin
                n_vec++;
                if (got_done0 !== 1'b0 || got_busy0 !== 1'b1 || got_init0 !== 8'h00) begin
                    n_err++; $display("FAIL b2b_restart: got done=%b busy=%b init=%h expected 0/1/00",
                                      got_done0, got_busy0, got_init0);
                end
            end
            n_vec++;
            if (got_n !== 256 || order_err !== 0 || got_done_cyc !== exp_done_cyc || got_xv !== exp_xv) begin
                n_err++;
                $display("FAIL b2b_sweep%0d: got n=%0d ord=%0d done=%0d xv=%0d expected 256/0/%0d/%0d",
                         pass, got_n, order_err, got_done_cyc, got_xv, exp_done_cyc, exp_xv);
            end
            for (int v = 0; v < 256; v++) begin
                n_vec++;
                if (got_kind[v] !== exp_kind[v] || got_state[v] !== exp_state[v] ||
                    got_steps[v] !== exp_steps[v] || got_cyc[v] !== exp_cyc[v]) begin
                    n_err++;
                    $display("FAIL b2b_rec%0d[%0d]: got %0d/%0d/%0d@%0d expected %0d/%0d/%0d@%0d", pass, v,
                             got_kind[v], got_state[v], got_steps[v], got_cyc[v],
                             exp_kind[v], exp_state[v], exp_steps[v], exp_cyc[v]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_all_zero();
        test_self_inhibit();
        test_rotate();
        test_cycle_inject();
        test_reset_mid_run();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
